data_axi_bridge: RTL and testbench

Data-side bridge that sits directly downstream of the MEM stage's SRAM-like data request port and converts it to single-beat AXI read/write transactions. Owns a single outstanding transaction; MEM holds its request until data_addr_ok and stalls until data_data_ok. Instruction side has its own bridge; an AXI crossbar at top level arbitrates the two. Constant AXI fields (id=1, len=0, burst=INCR, lock/cache/prot=0, wid=1, wlast=1) are tied at top level.

---
 rtl/data_axi_bridge.sv | 155 +++++++++++++++
 tb/tb_data_axi_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_axi_bridge.sv
// Bridges the MEM-stage SRAM-like data port to single-beat AXI reads/writes, one transaction at a time.
// Build option: define DATA_BRIDGE_POSTED_WRITE_EN to complete writes on AW+W instead of waiting for B.
module data_axi_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

  state_t      state, state_nxt;
  logic        accept, done_nxt, rd_load;
  logic        aw_pend, w_pend, aw_left, w_left;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  // Size 3 is never issued by MEM; fold it onto a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    done_nxt     = 1'b0;
    rd_load      = 1'b0;
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    aw_left      = aw_pend & ~awready;
    w_left       = w_pend & ~wready;
    case (state)
      IDLE: begin
        data_addr_ok = data_req;
        if (data_req) begin
          accept    = 1'b1;
          state_nxt = data_wr ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_D;
      end
      RD_D: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_load   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_AW: begin
        // AW and W retire independently; leave only once neither is outstanding.
        awvalid = aw_pend;
        wvalid  = w_pend;
        if (!aw_left && !w_left) begin
          state_nxt = WR_B;
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
          done_nxt  = 1'b1;
`endif
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_nxt = IDLE;
`ifdef DATA_BRIDGE_POSTED_WRITE_EN
          done_nxt  = 1'b0;
`else
          done_nxt  = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rdata   <= '0;
      data_data_ok <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_pend      <= 1'b0;
      w_pend       <= 1'b0;
    end else begin
      data_data_ok <= done_nxt;
      if (rd_load) data_rdata <= rdata;
      if (accept) begin
        size_q  <= norm_size(data_size);
        addr_q  <= data_addr & ADDR_MASK;
        wdata_q <= data_wdata;
        wstrb_q <= strb_of(norm_size(data_size), data_addr[1:0]);
        aw_pend <= data_wr;
        w_pend  <= data_wr;
      end else if (state == WR_AW) begin
        aw_pend <= aw_left;
        w_pend  <= w_left;
      end
    end
  end

  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: the bench plays both MEM and the AXI slave cycle by cycle.
module tb_data_axi_bridge;

`ifdef DATA_BRIDGE_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_bad = 0;

  data_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0; arready = 1'b0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    chk_val("rst_arvalid", 32'(arvalid), 32'd0);
    chk_val("rst_awvalid", 32'(awvalid), 32'd0);
    chk_val("rst_wvalid",  32'(wvalid),  32'd0);
    chk_val("rst_rready",  32'(rready),  32'd0);
    chk_val("rst_bready",  32'(bready),  32'd0);
    chk_val("rst_data_ok", 32'(data_data_ok), 32'd0);
    chk_val("rst_rdata",   data_rdata, 32'd0);
    rst = 1'b1;

    // Read word, zero-wait slave
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'hBFC0_0010; #1;
    chk_val("r1_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); data_req = 1'b0; #1;
    chk_val("r1_arvalid", 32'(arvalid), 32'd1);
    chk_val("r1_araddr",  araddr, 32'h1FC0_0010);
    chk_val("r1_arsize",  32'(arsize), 32'd2);
    chk_val("r1_addr_ok_busy", 32'(data_addr_ok), 32'd0);
    arready = 1'b1; tick(); arready = 1'b0; #1;
    chk_val("r1_rready",  32'(rready), 32'd1);
    chk_val("r1_ar_drop", 32'(arvalid), 32'd0);
    chk_val("r1_ok_early", 32'(data_data_ok), 32'd0);
    rvalid = 1'b1; rdata = 32'h1234_5678; tick(); rvalid = 1'b0; #1;
    chk_val("r1_data_ok", 32'(data_data_ok), 32'd1);
    chk_val("r1_rdata",   data_rdata, 32'h1234_5678);
    tick(); #1;
    chk_val("r1_ok_pulse", 32'(data_data_ok), 32'd0);

    // Write byte at offset 3, W accepted two cycles before AW
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_1003;
    data_wdata = 32'hAB00_0000; tick(); data_req = 1'b0; #1;
    chk_val("w1_wstrb",  32'(wstrb), 32'h8);
    chk_val("w1_awsize", 32'(awsize), 32'd0);
    chk_val("w1_awaddr", awaddr, 32'h0000_1003);
    chk_val("w1_wdata",  wdata, 32'hAB00_0000);
    chk_val("w1_wvalid", 32'(wvalid), 32'd1);
    wready = 1'b1; tick(); wready = 1'b0; #1;
    chk_val("w1_w_drop",   32'(wvalid), 32'd0);
    chk_val("w1_aw_hold",  32'(awvalid), 32'd1);
    chk_val("w1_bready_0", 32'(bready), 32'd0);
    tick(); #1;
    chk_val("w1_aw_hold2", 32'(awvalid), 32'd1);
    chk_val("w1_bready_1", 32'(bready), 32'd0);
    awready = 1'b1; tick(); awready = 1'b0; #1;
    chk_val("w1_aw_drop", 32'(awvalid), 32'd0);
    chk_val("w1_bready",  32'(bready), 32'd1);
    chk_val("w1_ok_at_b", 32'(data_data_ok), 32'(POSTED));
    bvalid = 1'b1; tick(); bvalid = 1'b0; #1;
    chk_val("w1_ok_after_b", 32'(data_data_ok), 32'(!POSTED));
    chk_val("w1_bready_off", 32'(bready), 32'd0);

    // Write half at offset 2, AW/W together, B after 4 idle cycles
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_2002;
    data_wdata = 32'h5678_0000; #1;
    chk_val("w2_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); data_req = 1'b0; #1;
    chk_val("w2_wstrb",  32'(wstrb), 32'hC);
    chk_val("w2_awsize", 32'(awsize), 32'd1);
    awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0; #1;
    chk_val("w2_bready", 32'(bready), 32'd1);
    chk_val("w2_valids", {30'd0, awvalid, wvalid}, 32'd0);
    chk_val("w2_ok_at_b", 32'(data_data_ok), 32'(POSTED));
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk_val("w2_ok_wait", 32'(data_data_ok), 32'd0);
    end
    tick();
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    // Back-to-back read offered in the completion cycle
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0100; #1;
    chk_val("w2_ok_after_b", 32'(data_data_ok), 32'(!POSTED));
    chk_val("b2b_addr_ok", 32'(data_addr_ok), 32'd1);

    // Read with AR stalled 5 cycles while data_req stays high
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_val("r2_arvalid", 32'(arvalid), 32'd1);
      chk_val("r2_araddr",  araddr, 32'h0000_0100);
      chk_val("r2_addr_ok", 32'(data_addr_ok), 32'd0);
      tick();
    end
    arready = 1'b1; tick(); arready = 1'b0; data_req = 1'b0; #1;
    chk_val("r2_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; tick(); rvalid = 1'b0; #1;
    chk_val("r2_data_ok", 32'(data_data_ok), 32'd1);
    chk_val("r2_rdata",   data_rdata, 32'hCAFE_F00D);
    tick(); #1;
    chk_val("r2_no_second", 32'(arvalid), 32'd0);

    // Size 3 is handled as a full word
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd3; data_addr = 32'h0000_0021;
    data_wdata = 32'h1122_3344; tick(); data_req = 1'b0; #1;
    chk_val("w3_wstrb",  32'(wstrb), 32'hF);
    chk_val("w3_awsize", 32'(awsize), 32'd2);
    awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; tick(); bvalid = 1'b0; tick();

    // Asynchronous reset while waiting in the R phase
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    tick(); data_req = 1'b0; arready = 1'b1; tick(); arready = 1'b0; #1;
    chk_val("rst_mid_rready_pre", 32'(rready), 32'd1);
    #2 rst = 1'b0; #1;
    chk_val("rst_mid_rready",  32'(rready), 32'd0);
    chk_val("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk_val("rst_mid_ok",      32'(data_data_ok), 32'd0);
    chk_val("rst_mid_rdata",   data_rdata, 32'd0);
    tick(); rst = 1'b1;
    data_req = 1'b1; data_addr = 32'hA000_0200; #1;
    chk_val("rst_post_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); data_req = 1'b0; #1;
    chk_val("rst_post_araddr", araddr, 32'h0000_0200);
    arready = 1'b1; tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_BEEF; tick(); rvalid = 1'b0; #1;
    chk_val("rst_post_rdata", data_rdata, 32'h0BAD_BEEF);
    tick();

`ifdef DATA_BRIDGE_POSTED_WRITE_EN
    // Posted write followed by a read that must wait for B
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0040;
    data_wdata = 32'hDEAD_0001; tick(); data_req = 1'b0;
    awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0; #1;
    chk_val("pw_ok_before_b", 32'(data_data_ok), 32'd1);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0044;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_val("pw_addr_ok_held", 32'(data_addr_ok), 32'd0);
      tick();
    end
    bvalid = 1'b1; tick(); bvalid = 1'b0; #1;
    chk_val("pw_ok_no_second", 32'(data_data_ok), 32'd0);
    chk_val("pw_addr_ok_after_b", 32'(data_addr_ok), 32'd1);
    tick(); data_req = 1'b0;
    arready = 1'b1; tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h5555_AAAA; tick(); rvalid = 1'b0; #1;
    chk_val("pw_read_rdata", data_rdata, 32'h5555_AAAA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
